merge_2x1_seq: RTL and testbench
================================

# merge_2x1_seq

Registered 2-to-1 merge unit for the accelerator NoC. It accepts two independent valid-tagged input lanes packed on one bus and forwards at most one word per cycle to a single output. When both lanes are valid, a last-served round-robin arbiter chooses between them. It is the sequential leaf merge element used to build reduction and merge trees; `i_cmd` is carried only for interface uniformity with the other NoC primitives.

## Interface
- `DATA_WIDTH`, default 32: width of one data word.
- `COMMAND_WIDTH`, default 2: width of `i_cmd`, which is ignored.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-high. Reset takes effect at a rising `clk` edge while `rst_n` = 1.
- `i_valid`  in  2: per-lane valid. Bit 0 is the low lane, bit 1 is the high lane.
- `i_data_bus`  in  2*DATA_WIDTH: low lane is [DATA_WIDTH-1:0]; high lane is [2*DATA_WIDTH-1:DATA_WIDTH].
- `i_en`  in  1: merge enable.
- `i_cmd`  in  COMMAND_WIDTH: unused; must not affect any output.
- `o_valid`  out  1: registered output valid.
- `o_data_bus`  out  DATA_WIDTH: registered output word.

## Operation
- The dummy word is all zeros. Whenever `o_valid` = 0, `o_data_bus` equals the dummy word.
- Arbiter state is a single `last_served` bit: 0 means low, 1 means high.
- On reset, `last_served` is set to 1, so the low lane wins the first contention.
- Per-cycle selection applies when not in reset and `i_en` = 1:
  - `i_valid` = 00: no transfer. The dummy word is produced with valid 0, and `last_served` is unchanged.
  - `i_valid` = 01: the low word is forwarded with valid 1, and `last_served` becomes 0.
  - `i_valid` = 10: the high word is forwarded with valid 1, and `last_served` becomes 1.
  - `i_valid` = 11: the lane with index `~last_served` is forwarded with valid 1, and `last_served` toggles.
- When `i_en` = 0:
  - The output registers load valid 0 and the dummy word.
  - `last_served` is held.
  - Inputs are dropped; there is no buffering.
- There is no backpressure. The unit always accepts one winner per cycle. The losing lane under contention is not stored, so it is the upstream's job to re-present it.
- Data passes through unmodified; there is no arithmetic.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset values: `o_valid` = 0, `o_data_bus` = 0, `last_served` = 1.
- Reset has priority over `i_en`.
- Reset asserted mid-stream clears the outputs at that edge. The first contention after reset goes to the low lane.
- Toggling `i_en` mid-stream takes effect on the next edge. Arbitration resumes from the held `last_served` value.
- A change of `i_data_bus` is reflected on the next edge. There is no output hold between beats.
- The outputs are not combinationally dependent on the inputs.

## Structure
- Shared package: `DATA_WIDTH` and `COMMAND_WIDTH` defaults, plus a dummy-word constant (all zeros). Other NoC primitives reuse these.
- One natural sub-module, `arbiter_rr_2`:
  - Combinational inputs `i_valid[1:0]` and `last_served`; outputs `grant_valid` and `grant_idx`.
  - Holds the `last_served` register update.
  - Reusable by the split and merge primitives.
- Top level: the data mux driven by `grant_idx`, plus the output registers.

## Test plan
All cases use DATA_WIDTH = 32.
- **Reset:** hold `rst_n` = 1 for 2 cycles with `i_valid` = 11 and `i_en` = 1 → `o_valid` = 0, `o_data_bus` = 0x00000000.
- **Single lanes:**
  - Low only: `i_valid` = 01, bus = {0xBBBBBBBB, 0xAAAAAAAA}, `i_en` = 1 → next cycle `o_valid` = 1, `o_data_bus` = 0xAAAAAAAA.
  - High only: `i_valid` = 10 → `o_data_bus` = 0xBBBBBBBB.
- **Contention after reset:** `i_valid` = 11 for 4 cycles, bus = {0xBBBBBBBB, 0xAAAAAAAA} → outputs AAAAAAAA, BBBBBBBB, AAAAAAAA, BBBBBBBB, all with `o_valid` = 1.
- **Disable mid-stream:** during contention, hold `i_en` = 0 for 2 cycles after a grant to high, then set `i_en` = 1 → output is valid 0 / zero word for 2 cycles, then the low lane wins (`last_served` was held); `i_cmd` toggling meanwhile has no effect.
- **Idle and invalid lanes:** `i_valid` = 00 with bus all 0xB → `o_valid` = 0, `o_data_bus` = 0, arbiter unchanged; `i_valid` = 01 with the high word differing → only the low word appears.
- **Reset mid-operation:** assert `rst_n` for 1 cycle while the last grant was low, then contend → the low lane wins first.

Source files
------------

// File: rtl/merge_2x1_seq_pkg.sv
// Shared definitions for the NoC merge/split primitives: default widths,
// lane identifiers and the dummy (all-zeros) word.
package merge_2x1_seq_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int COMMAND_WIDTH_DEF = 2;

  // Lane index as seen by the round-robin arbiter.
  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } lane_e;

  // Every bit of the dummy word; replicate to the required data width.
  localparam logic DUMMY_BIT = 1'b0;

  function automatic logic [DATA_WIDTH_DEF-1:0] dummy_word_def();
    return {DATA_WIDTH_DEF{DUMMY_BIT}};
  endfunction

endpackage

// File: rtl/merge_2x1_seq_arbiter_rr_2.sv
// Two-lane last-served round-robin arbiter. Grant is combinational from the
// valids and the held last_served bit; last_served advances only on a taken grant.
module arbiter_rr_2
  import merge_2x1_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  output logic       o_grant_valid,
  output logic       o_grant_idx,
  output logic       o_last_served
);

  lane_e r_last_served;
  lane_e w_last_served_nxt;
  lane_e w_grant_idx;

  always_comb begin
    o_grant_valid     = 1'b0;
    w_grant_idx       = LANE_LO;
    w_last_served_nxt = r_last_served;
    unique case (i_valid)
      2'b01: begin
        o_grant_valid = 1'b1;
        w_grant_idx   = LANE_LO;
      end
      2'b10: begin
        o_grant_valid = 1'b1;
        w_grant_idx   = LANE_HI;
      end
      2'b11: begin
        // Under contention the lane not served last wins, which toggles the state.
        o_grant_valid = 1'b1;
        w_grant_idx   = (r_last_served == LANE_HI) ? LANE_LO : LANE_HI;
      end
      default: begin
        o_grant_valid = 1'b0;
        w_grant_idx   = LANE_LO;
      end
    endcase
    if (i_en && o_grant_valid) begin
      w_last_served_nxt = w_grant_idx;
    end
  end

  // Reset to HI so the low lane wins the first contention.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_last_served <= LANE_HI;
    end else begin
      r_last_served <= w_last_served_nxt;
    end
  end

  assign o_grant_idx   = w_grant_idx;
  assign o_last_served = r_last_served;

endmodule

// File: rtl/merge_2x1_seq.sv
// Registered 2-to-1 merge leaf: picks at most one of two valid lanes per cycle
// (round-robin on contention) and forwards it one cycle later. No buffering.
module merge_2x1_seq
  import merge_2x1_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int COMMAND_WIDTH = COMMAND_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
  input  logic                      i_en,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data_bus
);

  localparam logic [DATA_WIDTH-1:0] DUMMY_WORD = {DATA_WIDTH{DUMMY_BIT}};

  logic                  w_grant_valid;
  logic                  w_grant_idx;
  logic                  w_last_served;
  logic [DATA_WIDTH-1:0] w_sel_word;
  logic                  w_unused_cmd;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // i_cmd exists only for interface uniformity with the other primitives.
  assign w_unused_cmd = ^{i_cmd, w_last_served};

  arbiter_rr_2 u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .i_en          (i_en),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx),
    .o_last_served (w_last_served)
  );

  assign w_sel_word = w_grant_idx ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : i_data_bus[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_valid <= 1'b0;
      r_data  <= DUMMY_WORD;
    end else if (i_en && w_grant_valid) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_word;
    end else begin
      r_valid <= 1'b0;
      r_data  <= DUMMY_WORD;
    end
  end

  assign o_valid    = r_valid;
  assign o_data_bus = r_data;

endmodule

// File: tb/tb_merge_2x1_seq.sv
// Bench for merge_2x1_seq: directed steps followed by random traffic, all
// checked against a lane-choice reference model held in the bench.
module tb_merge_2x1_seq;

  localparam int DW = 32;
  localparam int CW = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic            i_en;
  logic [CW-1:0]   i_cmd;
  logic            o_valid;
  logic [DW-1:0]   o_data_bus;

  int total;
  int bad;

  // Reference state: which lane was served most recently (0 low, 1 high).
  int model_last;
  logic [DW:0] exp_q[$];

  merge_2x1_seq #(.DATA_WIDTH(DW), .COMMAND_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n      = 1'b1;
    i_valid    = 2'b00;
    i_data_bus = '0;
    i_en       = 1'b0;
    i_cmd      = '0;
  end

  // Reference: decide the winner from the rules, return {valid, word}.
  function automatic logic [DW:0] model_step(input logic r, input logic en,
                                             input logic [1:0] v,
                                             input logic [2*DW-1:0] bus);
    int win;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    lo = bus[DW-1:0];
    hi = bus[2*DW-1:DW];
    if (r) begin
      model_last = 1;
      return {1'b0, {DW{1'b0}}};
    end
    if (!en || v == 2'b00) return {1'b0, {DW{1'b0}}};
    if (v == 2'b01)      win = 0;
    else if (v == 2'b10) win = 1;
    else                 win = 1 - model_last;
    model_last = win;
    return {1'b1, (win == 1) ? hi : lo};
  endfunction

  // Driver: apply one beat at the falling edge, then check after the rising edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [1:0] v, input logic [2*DW-1:0] bus,
                      input logic [CW-1:0] cmd);
    logic [DW:0] e;
    @(negedge clk);
    rst_n      = r;
    i_en       = en;
    i_valid    = v;
    i_data_bus = bus;
    i_cmd      = cmd;
    exp_q.push_back(model_step(r, en, v, bus));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (o_valid === e[DW]) else begin
      bad++;
      $error("FAIL %s_valid observed=%0b expected=%0b", tag, o_valid, e[DW]);
    end
    total++;
    assert (o_data_bus === e[DW-1:0]) else begin
      bad++;
      $error("FAIL %s_data observed=%h expected=%h", tag, o_data_bus, e[DW-1:0]);
    end
  endtask

  localparam logic [2*DW-1:0] BUS_AB = {32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [2*DW-1:0] BUS_BB = {32'hBBBBBBBB, 32'hBBBBBBBB};
  localparam logic [2*DW-1:0] BUS_CA = {32'hCCCCCCCC, 32'hAAAAAAAA};

  initial begin
    logic [2*DW-1:0] rbus;
    logic [1:0]      rv;
    logic            ren;
    logic            rrst;
    logic [CW-1:0]   rcmd;
    total      = 0;
    bad        = 0;
    model_last = 1;

    // Reset held with contention and enable present
    step("reset0", 1'b1, 1'b1, 2'b11, BUS_AB, 2'd0);
    step("reset1", 1'b1, 1'b1, 2'b11, BUS_AB, 2'd0);

    // Single lanes
    step("low_only",  1'b0, 1'b1, 2'b01, BUS_AB, 2'd0);
    step("high_only", 1'b0, 1'b1, 2'b10, BUS_AB, 2'd0);

    // Contention right after reset: A, B, A, B
    step("rst_pre_cont", 1'b1, 1'b1, 2'b11, BUS_AB, 2'd0);
    for (int i = 0; i < 4; i++) step("contend", 1'b0, 1'b1, 2'b11, BUS_AB, 2'd0);

    // Disable mid-stream after a high grant, cmd toggling
    step("disable0", 1'b0, 1'b0, 2'b11, BUS_AB, 2'd1);
    step("disable1", 1'b0, 1'b0, 2'b11, BUS_AB, 2'd2);
    step("resume",   1'b0, 1'b1, 2'b11, BUS_AB, 2'd3);

    // Idle lanes keep arbiter state; masked high word never leaks
    step("idle",       1'b0, 1'b1, 2'b00, BUS_BB, 2'd0);
    step("after_idle", 1'b0, 1'b1, 2'b11, BUS_AB, 2'd0);
    step("low_masked", 1'b0, 1'b1, 2'b01, BUS_CA, 2'd1);

    // Reset mid-operation with last grant low: low still wins first
    step("mid_reset",  1'b1, 1'b1, 2'b11, BUS_AB, 2'd0);
    step("post_rst0",  1'b0, 1'b1, 2'b11, BUS_AB, 2'd0);
    step("post_rst1",  1'b0, 1'b1, 2'b11, BUS_AB, 2'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rbus = {$urandom(), $urandom()};
      rv   = 2'($urandom_range(0, 3));
      ren  = ($urandom_range(0, 7) != 0);
      rrst = ($urandom_range(0, 31) == 0);
      rcmd = CW'($urandom_range(0, 3));
      step("random", rrst, ren, rv, rbus, rcmd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
